// File: rtl/tl_pkg.sv
// Shared definitions for the intersection phase scheduler.
//   - one-hot state indices, state width and the enumerated state type
//   - lamp encodings {R,Y,G} = bits [2:0]
//   - the all-zero (illegal) state vector
//   - road identifier used to remember which road was served last
package tl_pkg;

    localparam int ST_W = 8;

    localparam int S_INIT  = 0;
    localparam int S_A_G   = 1;
    localparam int S_A_Y   = 2;
    localparam int S_A_CLR = 3;
    localparam int S_B_G   = 4;
    localparam int S_B_Y   = 5;
    localparam int S_B_CLR = 6;
    localparam int S_WALK  = 7;

    typedef enum logic [ST_W-1:0] {
        ST_INIT  = ST_W'(1) << S_INIT,
        ST_A_G   = ST_W'(1) << S_A_G,
        ST_A_Y   = ST_W'(1) << S_A_Y,
        ST_A_CLR = ST_W'(1) << S_A_CLR,
        ST_B_G   = ST_W'(1) << S_B_G,
        ST_B_Y   = ST_W'(1) << S_B_Y,
        ST_B_CLR = ST_W'(1) << S_B_CLR,
        ST_WALK  = ST_W'(1) << S_WALK
    } state_t;

    localparam logic [ST_W-1:0] ST_ZERO = '0;

    localparam logic [2:0] LAMP_R = 3'b100;
    localparam logic [2:0] LAMP_Y = 3'b010;
    localparam logic [2:0] LAMP_G = 3'b001;

    typedef enum logic {
        ROAD_A = 1'b0,
        ROAD_B = 1'b1
    } road_t;

endpackage

// File: rtl/tl_phase_timer.sv
// Phase timer: CNT_W-wide up-counter that saturates at all-ones.
//   clk   in  clock, rising edge
//   reset in  synchronous active-high reset (cnt -> 0)
//   clr   in  synchronous clear, asserted on every phase change
//   cnt   out cycles spent in the current phase
module tl_phase_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            cnt <= '0;
        end else if (cnt != '1) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/tl_intersection_sched.sv
// Phase scheduler for a two-road intersection with a pedestrian crossing.
// Moore FSM with a one-hot state register; outputs decode the state only.
//   clk      in  clock, rising edge
//   reset    in  synchronous active-high reset
//   req_a    in  vehicle present on road A (level)
//   req_b    in  vehicle present on road B (level)
//   ped_req  in  pedestrian button, latched internally
//   pass     in  synchronous restart override (back to INIT)
//   light_a  out road A lamps, one-hot {R,Y,G}
//   light_b  out road B lamps, one-hot {R,Y,G}
//   walk     out pedestrian walk lamp
//   phase    out one-hot current state
module tl_intersection_sched
    import tl_pkg::*;
#(
    parameter int CNT_W   = 8,
    parameter int G_MIN   = 8,
    parameter int G_MAX   = 32,
    parameter int Y_TIME  = 3,
    parameter int AR_TIME = 2,
    parameter int W_TIME  = 6
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_a,
    input  logic            req_b,
    input  logic            ped_req,
    input  logic            pass,
    output logic [2:0]      light_a,
    output logic [2:0]      light_b,
    output logic            walk,
    output logic [ST_W-1:0] phase
);

    // Last cycle index of each timed phase (a phase of T cycles ends at cnt == T-1).
    localparam logic [CNT_W-1:0] G_MIN_END = CNT_W'(G_MIN - 1);
    localparam logic [CNT_W-1:0] G_MAX_END = CNT_W'(G_MAX - 1);
    localparam logic [CNT_W-1:0] Y_END     = CNT_W'(Y_TIME - 1);
    localparam logic [CNT_W-1:0] AR_END    = CNT_W'(AR_TIME - 1);
    localparam logic [CNT_W-1:0] W_END     = CNT_W'(W_TIME - 1);

    state_t           state;
    state_t           state_nx;
    logic [CNT_W-1:0] cnt;
    logic             timer_clr;
    logic             ped_pend;
    logic             ped_pend_nx;
    road_t            last;
    road_t            last_nx;
    logic             entering;

    tl_phase_timer #(
        .CNT_W(CNT_W)
    ) u_timer (
        .clk  (clk),
        .reset(reset),
        .clr  (timer_clr),
        .cnt  (cnt)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_INIT;
            ped_pend <= 1'b0;
            last     <= ROAD_B;
        end else begin
            state    <= state_nx;
            ped_pend <= ped_pend_nx;
            last     <= last_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_INIT:  if (cnt == AR_END) state_nx = ST_A_G;
            // Hand over only when the minimum green has elapsed, someone else
            // is waiting, and either the own road has emptied or max green hit.
            ST_A_G:   if (cnt >= G_MIN_END && (req_b || ped_pend) &&
                          (!req_a || cnt >= G_MAX_END)) state_nx = ST_A_Y;
            ST_A_Y:   if (cnt == Y_END) state_nx = ST_A_CLR;
            ST_A_CLR: if (cnt == AR_END) state_nx = ped_pend ? ST_WALK : ST_B_G;
            ST_B_G:   if (cnt >= G_MIN_END && (req_a || ped_pend) &&
                          (!req_b || cnt >= G_MAX_END)) state_nx = ST_B_Y;
            ST_B_Y:   if (cnt == Y_END) state_nx = ST_B_CLR;
            ST_B_CLR: if (cnt == AR_END) state_nx = ped_pend ? ST_WALK : ST_A_G;
            ST_WALK:  if (cnt == W_END) state_nx = (last == ROAD_B) ? ST_A_G : ST_B_G;
            // Zero or multi-hot vectors recover through INIT.
            default:  state_nx = ST_INIT;
        endcase
        if (pass) state_nx = ST_INIT;

        entering = (state_nx != state);

        last_nx = last;
        if (entering && state_nx == ST_A_G) last_nx = ROAD_A;
        else if (entering && state_nx == ST_B_G) last_nx = ROAD_B;

        // Presses during WALK are dropped; elsewhere a press wins over the
        // clear that happens when WALK is entered.
        ped_pend_nx = ped_pend;
        if (ped_req && state != ST_WALK) ped_pend_nx = 1'b1;
        else if (entering && state_nx == ST_WALK) ped_pend_nx = 1'b0;

        if (pass) begin
            ped_pend_nx = 1'b0;
            last_nx     = ROAD_B;
        end

        // pass also clears the timer while already in INIT, so holding it
        // keeps INIT pinned at cnt == 0.
        timer_clr = pass || entering;
    end

    always_comb begin
        light_a = LAMP_R;
        light_b = LAMP_R;
        walk    = 1'b0;
        case (state)
            ST_A_G:  light_a = LAMP_G;
            ST_A_Y:  light_a = LAMP_Y;
            ST_B_G:  light_b = LAMP_G;
            ST_B_Y:  light_b = LAMP_Y;
            ST_WALK: walk    = 1'b1;
            default: ;
        endcase
        phase = state;
    end

endmodule

// File: tb/tb_tl_intersection_sched.sv
// Testbench for tl_intersection_sched: expected per-cycle outputs are pushed
// to a queue as each scenario is set up and popped/compared once per cycle.
module tb_tl_intersection_sched;

    localparam logic [7:0] P_INIT  = 8'b0000_0001;
    localparam logic [7:0] P_A_G   = 8'b0000_0010;
    localparam logic [7:0] P_A_Y   = 8'b0000_0100;
    localparam logic [7:0] P_A_CLR = 8'b0000_1000;
    localparam logic [7:0] P_B_G   = 8'b0001_0000;
    localparam logic [7:0] P_B_Y   = 8'b0010_0000;
    localparam logic [7:0] P_B_CLR = 8'b0100_0000;
    localparam logic [7:0] P_WALK  = 8'b1000_0000;

    localparam logic [2:0] R = 3'b100;
    localparam logic [2:0] Y = 3'b010;
    localparam logic [2:0] G = 3'b001;

    typedef struct packed {
        logic [7:0] ph;
        logic [2:0] la;
        logic [2:0] lb;
        logic       w;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       req_a = 1'b0;
    logic       req_b = 1'b0;
    logic       ped_req = 1'b0;
    logic       pass = 1'b0;
    logic [2:0] light_a;
    logic [2:0] light_b;
    logic       walk;
    logic [7:0] phase;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_fail = 0;

    tl_intersection_sched dut (
        .clk    (clk),
        .reset  (reset),
        .req_a  (req_a),
        .req_b  (req_b),
        .ped_req(ped_req),
        .pass   (pass),
        .light_a(light_a),
        .light_b(light_b),
        .walk   (walk),
        .phase  (phase)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout: checks=%0d failures=%0d", n_chk, n_fail);
        $fatal(1, "watchdog");
    end

    function automatic exp_t mk(input logic [7:0] ph);
        exp_t e;
        e.ph = ph;
        e.la = R;
        e.lb = R;
        e.w  = 1'b0;
        if (ph == P_A_G) e.la = G;
        if (ph == P_A_Y) e.la = Y;
        if (ph == P_B_G) e.lb = G;
        if (ph == P_B_Y) e.lb = Y;
        if (ph == P_WALK) e.w = 1'b1;
        return e;
    endfunction

    task automatic push(input logic [7:0] ph, input int n);
        for (int i = 0; i < n; i++) sb.push_back(mk(ph));
    endtask

    // Leaves the bench at the falling edge of cycle 0 (INIT, cnt 0).
    task automatic do_reset();
        @(negedge clk);
        reset   = 1'b1;
        ped_req = 1'b0;
        pass    = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        exp_t e;
        reset = 1'b1; req_a = 1'b1; req_b = 1'b1; ped_req = 1'b1; pass = 1'b1;
        repeat (3) @(negedge clk);
        push(P_INIT, 1);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            n_chk++;
            if ({phase, light_a, light_b, walk} !== e) begin
                n_fail++;
                $display("FAIL reset_state got ph=%b la=%b lb=%b w=%b need ph=%b la=%b lb=%b w=%b",
                         phase, light_a, light_b, walk, e.ph, e.la, e.lb, e.w);
            end
        end
        reset = 1'b0; req_a = 1'b0; req_b = 1'b0; ped_req = 1'b0; pass = 1'b0;
    endtask

    task automatic test_idle();
        exp_t e;
        int idx = 0;
        req_a = 1'b0; req_b = 1'b0;
        do_reset();
        push(P_INIT, 2);
        push(P_A_G, 200);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            n_chk++;
            if ({phase, light_a, light_b, walk} !== e) begin
                n_fail++;
                $display("FAIL idle cyc=%0d got ph=%b la=%b lb=%b w=%b need ph=%b la=%b lb=%b w=%b",
                         idx, phase, light_a, light_b, walk, e.ph, e.la, e.lb, e.w);
            end
            idx++;
            @(negedge clk);
        end
    endtask

    task automatic test_req_b();
        exp_t e;
        int idx = 0;
        req_a = 1'b0; req_b = 1'b1;
        do_reset();
        push(P_INIT, 2); push(P_A_G, 8); push(P_A_Y, 3); push(P_A_CLR, 2);
        push(P_B_G, 20);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            n_chk++;
            if ({phase, light_a, light_b, walk} !== e) begin
                n_fail++;
                $display("FAIL req_b cyc=%0d got ph=%b la=%b lb=%b w=%b need ph=%b la=%b lb=%b w=%b",
                         idx, phase, light_a, light_b, walk, e.ph, e.la, e.lb, e.w);
            end
            idx++;
            @(negedge clk);
        end
        req_b = 1'b0;
    endtask

    task automatic test_both_max();
        exp_t e;
        int idx = 0;
        req_a = 1'b1; req_b = 1'b1;
        do_reset();
        push(P_INIT, 2);
        push(P_A_G, 32); push(P_A_Y, 3); push(P_A_CLR, 2);
        push(P_B_G, 32); push(P_B_Y, 3); push(P_B_CLR, 2);
        push(P_A_G, 32); push(P_A_Y, 1);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            n_chk++;
            if ({phase, light_a, light_b, walk} !== e || (light_a != R && light_b != R)) begin
                n_fail++;
                $display("FAIL both_max cyc=%0d got ph=%b la=%b lb=%b w=%b need ph=%b la=%b lb=%b w=%b",
                         idx, phase, light_a, light_b, walk, e.ph, e.la, e.lb, e.w);
            end
            idx++;
            @(negedge clk);
        end
        req_a = 1'b0; req_b = 1'b0;
    endtask

    task automatic test_ped();
        exp_t e;
        int idx = 0;
        req_a = 1'b0; req_b = 1'b0;
        do_reset();
        push(P_INIT, 2); push(P_A_G, 8); push(P_A_Y, 3); push(P_A_CLR, 2);
        push(P_WALK, 6); push(P_B_G, 20);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            n_chk++;
            if ({phase, light_a, light_b, walk} !== e) begin
                n_fail++;
                $display("FAIL ped cyc=%0d got ph=%b la=%b lb=%b w=%b need ph=%b la=%b lb=%b w=%b",
                         idx, phase, light_a, light_b, walk, e.ph, e.la, e.lb, e.w);
            end
            // Pulse at A_G cycle 5 (cyc 7), second pulse mid-WALK (cyc 17).
            ped_req = (idx == 7) || (idx == 17);
            idx++;
            @(negedge clk);
        end
        ped_req = 1'b0;
    endtask

    task automatic test_pass();
        exp_t e;
        int idx = 0;
        req_a = 1'b0; req_b = 1'b0;
        do_reset();
        push(P_INIT, 2); push(P_A_G, 8); push(P_A_Y, 1);
        push(P_INIT, 5); push(P_A_G, 30);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            n_chk++;
            if ({phase, light_a, light_b, walk} !== e) begin
                n_fail++;
                $display("FAIL pass cyc=%0d got ph=%b la=%b lb=%b w=%b need ph=%b la=%b lb=%b w=%b",
                         idx, phase, light_a, light_b, walk, e.ph, e.la, e.lb, e.w);
            end
            // ped press latches before A_Y; pass held cyc 10..13 with a
            // press inside the pass window that must be discarded.
            ped_req = (idx == 7) || (idx == 12);
            pass    = (idx >= 10) && (idx <= 13);
            idx++;
            @(negedge clk);
        end
        ped_req = 1'b0; pass = 1'b0;
    endtask

    task automatic test_reset_mid_bg();
        exp_t e;
        int idx = 0;
        req_a = 1'b0; req_b = 1'b1;
        do_reset();
        push(P_INIT, 2); push(P_A_G, 8); push(P_A_Y, 3); push(P_A_CLR, 2);
        push(P_B_G, 4);
        push(P_INIT, 2); push(P_A_G, 8); push(P_A_Y, 3); push(P_A_CLR, 2);
        push(P_B_G, 5);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            n_chk++;
            if ({phase, light_a, light_b, walk} !== e) begin
                n_fail++;
                $display("FAIL reset_mid_bg cyc=%0d got ph=%b la=%b lb=%b w=%b need ph=%b la=%b lb=%b w=%b",
                         idx, phase, light_a, light_b, walk, e.ph, e.la, e.lb, e.w);
            end
            reset = (idx == 18);
            idx++;
            @(negedge clk);
        end
        reset = 1'b0; req_b = 1'b0;
    endtask

    initial begin
        test_reset();
        test_idle();
        test_req_b();
        test_both_max();
        test_ped();
        test_pass();
        test_reset_mid_bg();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/tl_intersection_sched.md
Name: tl_intersection_sched

Overview:
- Phase scheduler for a two-road intersection with a pedestrian crossing. It sequences the light datapath and gives the shared intersection to one road at a time, or to pedestrians.
- Moore FSM with a one-hot state register and an internal phase timer.
- Inputs: vehicle sensor requests and a latched pedestrian request. Outputs: per-road lamp drive, walk lamp, and phase status for the top level.

Parameters:
- CNT_W, 8, phase timer width; all durations must be ≤ 2^CNT_W.
- G_MIN, 8, minimum green cycles per road.
- G_MAX, 32, maximum green cycles while the own road still requests.
- Y_TIME, 3, yellow cycles.
- AR_TIME, 2, all-red clearance cycles.
- W_TIME, 6, pedestrian walk cycles.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- req_a  in  1  vehicle present on road A (level).
- req_b  in  1  vehicle present on road B (level).
- ped_req  in  1  pedestrian button; a one-cycle pulse is sufficient.
- pass  in  1  synchronous restart override.
- light_a  out  3  road A lamps, one-hot {R,Y,G} = bits [2:0].
- light_b  out  3  road B lamps, same encoding.
- walk  out  1  pedestrian walk lamp.
- phase  out  8  one-hot current state, for status/debug.

Behaviour:
- States, one-hot: INIT, A_G, A_Y, A_CLR, B_G, B_Y, B_CLR, WALK. Outputs decode the state register only (no input-to-output paths).
- Reset (synchronous):
  - state=INIT, cnt=0, ped_pend=0, last=B (road A is served first).
  - Both lights = R (3'b100), walk=0, phase=INIT.
- Timer:
  - cnt clears on every state change; otherwise it increments, saturating at all-ones.
  - A timed state of duration T therefore occupies exactly T cycles.
- Transitions:
  - INIT → A_G when cnt == AR_TIME-1. INIT is all-red.
  - A_G → A_Y when all of:
    - cnt ≥ G_MIN-1, and
    - competitor pending (req_b | ped_pend), and
    - (!req_a or cnt ≥ G_MAX-1).
  - With no competitor, A_G holds indefinitely.
  - A_Y → A_CLR at cnt == Y_TIME-1.
  - A_CLR → exits at cnt == AR_TIME-1 to WALK if ped_pend, else to B_G.
  - B_G, B_Y, B_CLR mirror the A states, with req_a as the competitor.
  - WALK → exits at cnt == W_TIME-1 to the green of the road not equal to `last`. `last` updates on entry to A_G or B_G.
- Pedestrian latch:
  - ped_pend sets on ped_req and clears on entry to WALK.
  - A ped_req during WALK is ignored; set has priority over clear only outside WALK.
- Lamps:
  - A_G: light_a=G, light_b=R.
  - A_Y: light_a=Y, light_b=R.
  - B_G and B_Y mirror this.
  - INIT, A_CLR, B_CLR, WALK: both R.
  - walk=1 only in WALK.
  - Never two non-red roads at once; walk is never asserted with any non-red.
- pass:
  - Next state = INIT, cnt=0, ped_pend=0, last=B.
  - Overrides all transitions and ped_req in the same cycle.
  - pass held high keeps the block in INIT.
- Priority: reset > pass > normal transitions.
- Illegal or zero state vector: next state INIT.

Decomposition:
- Shared package tl_pkg:
  - state index constants and state width;
  - lamp encodings (LAMP_R/Y/G);
  - the all-zero state vector.
- One sub-module, tl_phase_timer:
  - ports: clk, reset, clr, cnt;
  - CNT_W-wide saturating counter.
- Duration comparisons stay in the scheduler.

Test Plan:
- No requests after reset → INIT for 2 cycles with both R; A_G from cycle 2; A_G held for 200 cycles; walk=0 throughout.
- req_b held high from cycle 0, req_a=0 → A_G 8 cycles, A_Y 3, A_CLR 2, then B_G. B_G holds while req_a=0.
- req_a and req_b both held high → A_G lasts 32 cycles, then A_Y 3, A_CLR 2, B_G 32, repeating. Lights never both non-red.
- ped_req one-cycle pulse at cycle 5 of A_G, no vehicles → A_G exits at 8 cycles; A_Y 3, A_CLR 2, WALK 6 with walk=1 and both R; then B_G. A second ped_req during WALK produces no second WALK.
- pass pulse during A_Y with ped_pend=1 → next cycle phase=INIT, both R, cnt=0. After 2 cycles A_G, and no WALK occurs.
- reset asserted mid-B_G for 1 cycle → next cycle state=INIT and all outputs at reset values. The sequence restarts with A served first.
